// File: rtl/ifetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// ifetch_unit_pkg
// Definitions shared by the instruction-fetch slice: the halt opcode, the
// native instruction width and the default reset PC, plus a helper that
// recognises a halt word from its opcode field.
// No ports (package).
// ----------------------------------------------------------------------------
package ifetch_unit_pkg;

    localparam int          INSTR_WIDTH      = 16;
    localparam logic [3:0]  OPC_HLT          = 4'hF;
    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

    function automatic logic is_hlt(input logic [3:0] opcode);
        return opcode == OPC_HLT;
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// ----------------------------------------------------------------------------
// ifetch_fifo
// Two-entry prefetch buffer of {pc, word}. The head entry is always held in
// the head_* registers, so decode sees it without any read mux.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   push, push_pc/word   write a new entry (ignored when full without a pop)
//   pop                  discard the head entry (ignored when empty)
//   flush                empty the buffer; overrides push and pop
//   head_pc, head_word   current head entry (stale when count == 0)
//   count                number of valid entries, 0..2
// ----------------------------------------------------------------------------
module ifetch_fifo #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [AWIDTH-1:0] push_pc,
    input  logic [DWIDTH-1:0] push_word,
    input  logic              pop,
    input  logic              flush,
    output logic [AWIDTH-1:0] head_pc,
    output logic [DWIDTH-1:0] head_word,
    output logic [1:0]        count
);

    logic [AWIDTH-1:0] tail_pc;
    logic [DWIDTH-1:0] tail_word;
    logic              do_pop;
    logic              do_push;

    assign do_pop  = pop && (count != 2'd0);
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign do_push = push && ((count != 2'd2) || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= 2'd0;
            // NOTE: only two entries, so the storage is reset too; this keeps
            // the head outputs deterministic without a RAM-style no-reset array.
            head_pc   <= '0;
            head_word <= '0;
            tail_pc   <= '0;
            tail_word <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_pc   <= push_pc;
                        head_word <= push_word;
                    end else begin
                        tail_pc   <= push_pc;
                        tail_word <= push_word;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_pc   <= tail_pc;
                    head_word <= tail_word;
                    count     <= count - 2'd1;
                end
                2'b11: begin
                    // Count unchanged; the new word lands behind whatever remains.
                    if (count == 2'd1) begin
                        head_pc   <= push_pc;
                        head_word <= push_word;
                    end else begin
                        head_pc   <= tail_pc;
                        head_word <= tail_word;
                        tail_pc   <= push_pc;
                        tail_word <= push_word;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// ----------------------------------------------------------------------------
// ifetch_unit
// Instruction fetch front end: drives a zero-latency instruction memory,
// buffers up to two fetched words and presents the head to decode.
// Optional halt detection is enabled by defining IFETCH_HALT_DETECT_EN: a
// fetched word with opcode 4'hF stops further fetching and, once the buffer
// drains, raises halted until the next redirect or reset.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   mem_addr, mem_enable       fetch address (0 when idle) and read strobe
//   mem_wr, mem_data_in        write side, constant 0
//   mem_data_out               combinational read data
//   redirect, redirect_pc      branch/jump target (bit 0 ignored)
//   instr, instr_pc            head instruction and its address (0 if invalid)
//   instr_valid, instr_ready   head handshake with decode
//   halted                     halt fetched and buffer drained
// ----------------------------------------------------------------------------
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter int                DWIDTH   = INSTR_WIDTH,
    parameter int                AWIDTH   = 16,
    parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [DWIDTH-1:0] mem_data_in,
    input  logic [DWIDTH-1:0] mem_data_out,
    input  logic              redirect,
    input  logic [AWIDTH-1:0] redirect_pc,
    output logic [DWIDTH-1:0] instr,
    output logic [AWIDTH-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              halted
);

    localparam logic [AWIDTH-1:0] HALF_MASK = ~AWIDTH'(1);

    logic [AWIDTH-1:0] fetch_pc;
    logic [AWIDTH-1:0] head_pc;
    logic [DWIDTH-1:0] head_word;
    logic [1:0]        count;
    logic              pop;
    logic              fetch;

    assign pop = instr_valid && instr_ready;

`ifdef IFETCH_HALT_DETECT_EN
    logic halt_seen;

    assign fetch  = !redirect && !halt_seen && ((count != 2'd2) || pop);
    assign halted = halt_seen && (count == 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_seen <= 1'b0;
        end else if (redirect) begin
            halt_seen <= 1'b0;
        end else if (fetch && is_hlt(mem_data_out[DWIDTH-1 -: 4])) begin
            halt_seen <= 1'b1;
        end
    end
`else
    assign fetch  = !redirect && ((count != 2'd2) || pop);
    assign halted = 1'b0;
`endif

    // The registers are already held by reset; the strobe alone needs the
    // explicit gate so memory sees no read while it is being loaded.
    assign mem_enable  = fetch && !rst;
    assign mem_addr    = mem_enable ? fetch_pc : '0;
    assign mem_wr      = 1'b0;
    assign mem_data_in = '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC & HALF_MASK;
        end else if (redirect) begin
            fetch_pc <= redirect_pc & HALF_MASK;
        end else if (fetch) begin
            fetch_pc <= fetch_pc + AWIDTH'(2);   // wraps naturally at the top
        end
    end

    ifetch_fifo #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fetch),
        .push_pc   (fetch_pc),
        .push_word (mem_data_out),
        .pop       (pop),
        .flush     (redirect),
        .head_pc   (head_pc),
        .head_word (head_word),
        .count     (count)
    );

    assign instr_valid = (count != 2'd0);
    assign instr       = instr_valid ? head_word : '0;
    assign instr_pc    = instr_valid ? head_pc   : '0;

endmodule
